// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch path.
package core_pkg;

  localparam int PC_W = 16;

  typedef logic [31:0]     ins_t;
  typedef logic [PC_W-1:0] pc_t;

  localparam ins_t NOP              = 32'h0000_0013;
  localparam pc_t  DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, ins} pairs; clear overrides push and pop.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_pc,
  input  ins_t          i_push_ins,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [CW-1:0] o_count,
  output logic [AW-1:0] o_head_pc,
  output ins_t          o_head_ins
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_pc_mem  [DEPTH];
  ins_t          r_ins_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: storage is reset so the head reads zero straight out of reset;
      // this keeps the memory in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= '0;
        r_ins_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_pc_mem[r_wr_ptr]  <= i_push_pc;
        r_ins_mem[r_wr_ptr] <= i_push_ins;
        r_wr_ptr            <= next_ptr(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count    = r_cnt;
  assign o_head_pc  = r_pc_mem[r_rd_ptr];
  assign o_head_ins = r_ins_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word-aligned SRAM reads, buffers responses and
// hands {pc, ins} pairs to decode; a redirect flushes and restarts fetch.
module ifetch
  import core_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [AW-1:0] ins_a,
  output logic          ins_e,
  input  ins_t          ins,
  input  logic          redir_e,
  input  logic [AW-1:0] redir_pc,
  output logic          dec_vld,
  input  logic          dec_rdy,
  output ins_t          dec_ins,
  output logic [AW-1:0] dec_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_pc;
  logic          r_infl_q;
  logic [AW-1:0] r_infl_pc_q;

  logic [CW-1:0] w_cnt;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_need;
  logic [CW:0]   w_cap;
  logic          w_unused_lo;

  assign w_pop  = dec_vld & dec_rdy;
  assign w_push = r_infl_q & ~redir_e;

  // Issue only when the response is guaranteed a slot; a same-cycle pop frees one.
  assign w_need  = {1'b0, w_cnt} + (CW+1)'(r_infl_q);
  assign w_cap   = (CW+1)'(DEPTH) + (CW+1)'(w_pop);
  // Gating with rstn keeps the strobe low for the whole reset, not just after an edge.
  assign w_issue = rstn & ~redir_e & (w_need < w_cap);

  assign ins_e       = w_issue;
  assign ins_a       = r_pc;
  assign dec_vld     = (w_cnt != '0);
  assign w_unused_lo = ^redir_pc[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc        <= RESET_PC;
      r_infl_q    <= 1'b0;
      r_infl_pc_q <= '0;
    end else if (redir_e) begin
      r_pc     <= {redir_pc[AW-1:2], 2'b00};
      r_infl_q <= 1'b0;
    end else begin
      r_infl_q <= w_issue;
      if (w_issue) begin
        r_pc        <= r_pc + AW'(4);
        r_infl_pc_q <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_push_pc  (r_infl_pc_q),
    .i_push_ins (ins),
    .i_pop      (w_pop & ~redir_e),
    .i_clear    (redir_e),
    .o_count    (w_cnt),
    .o_head_pc  (dec_pc),
    .o_head_ins (dec_ins)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cycle-by-cycle vector table plus reset sequences.
module tb_ifetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ins_a;
  logic        ins_e;
  ins_t        ins = NOP;
  logic        redir_e;
  logic [15:0] redir_pc;
  logic        dec_vld;
  logic        dec_rdy;
  ins_t        dec_ins;
  logic [15:0] dec_pc;

  int n_checks = 0;
  int n_errors = 0;

  ifetch #(.AW(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ins_a    (ins_a),
    .ins_e    (ins_e),
    .ins      (ins),
    .redir_e  (redir_e),
    .redir_pc (redir_pc),
    .dec_vld  (dec_vld),
    .dec_rdy  (dec_rdy),
    .dec_ins  (dec_ins),
    .dec_pc   (dec_pc)
  );

  always #5 clk = ~clk;

  function automatic ins_t sram_word(input logic [15:0] a);
    return 32'h0010_0093 + {18'b0, a[15:2]};
  endfunction

  // SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (ins_e) ins <= sram_word(ins_a);
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        e_en;
    logic [15:0] e_a;
    logic        e_vld;
    logic [15:0] e_pc;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic rdy, input logic redir, input logic [15:0] rpc,
                         input logic en, input logic [15:0] a, input logic vld, input logic [15:0] pc);
    tv[i].rdy   = rdy;
    tv[i].redir = redir;
    tv[i].rpc   = rpc;
    tv[i].e_en  = en;
    tv[i].e_a   = a;
    tv[i].e_vld = vld;
    tv[i].e_pc  = pc;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    dec_rdy  = tv[i].rdy;
    redir_e  = tv[i].redir;
    redir_pc = tv[i].rpc;
    #1;
    check($sformatf("c%0d ins_e", i), 32'(ins_e), 32'(tv[i].e_en));
    check($sformatf("c%0d ins_a", i), 32'(ins_a), 32'(tv[i].e_a));
    check($sformatf("c%0d dec_vld", i), 32'(dec_vld), 32'(tv[i].e_vld));
    if (tv[i].e_vld) begin
      check($sformatf("c%0d dec_pc", i), 32'(dec_pc), 32'(tv[i].e_pc));
      check($sformatf("c%0d dec_ins", i), dec_ins, sram_word(tv[i].e_pc));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ins_e"},   32'(ins_e),   32'h0);
    check({tag, " ins_a"},   32'(ins_a),   32'h0);
    check({tag, " dec_vld"}, 32'(dec_vld), 32'h0);
    check({tag, " dec_pc"},  32'(dec_pc),  32'h0);
    check({tag, " dec_ins"}, dec_ins,      32'h0);
  endtask

  initial begin
    // Cycle 0 is the first cycle with rstn high.
    set_vec( 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    set_vec( 1, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000);
    set_vec( 2, 1, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000);
    set_vec( 3, 1, 0, 16'h0000, 1, 16'h000C, 1, 16'h0004);
    set_vec( 4, 1, 0, 16'h0000, 1, 16'h0010, 1, 16'h0008);
    for (int i = 5; i <= 10; i++)
      set_vec(i, 0, 0, 16'h0000, 0, 16'h0014, 1, 16'h000C);
    set_vec(11, 1, 0, 16'h0000, 1, 16'h0014, 1, 16'h000C);
    set_vec(12, 1, 0, 16'h0000, 1, 16'h0018, 1, 16'h0010);
    set_vec(13, 1, 0, 16'h0000, 1, 16'h001C, 1, 16'h0014);
    set_vec(14, 0, 1, 16'h0100, 0, 16'h0020, 1, 16'h0018);
    set_vec(15, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000);
    set_vec(16, 1, 0, 16'h0000, 1, 16'h0104, 0, 16'h0000);
    set_vec(17, 1, 0, 16'h0000, 1, 16'h0108, 1, 16'h0100);
    set_vec(18, 1, 0, 16'h0000, 1, 16'h010C, 1, 16'h0104);
    set_vec(19, 1, 1, 16'h0102, 0, 16'h0110, 1, 16'h0108);
    set_vec(20, 1, 1, 16'h0200, 0, 16'h0100, 0, 16'h0000);
    set_vec(21, 1, 1, 16'hFFFE, 0, 16'h0200, 0, 16'h0000);
    set_vec(22, 1, 0, 16'h0000, 1, 16'hFFFC, 0, 16'h0000);
    set_vec(23, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    set_vec(24, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'hFFFC);
    set_vec(25, 1, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000);
    set_vec(26, 1, 0, 16'h0000, 1, 16'h000C, 1, 16'h0004);
    set_vec(27, 0, 0, 16'h0000, 0, 16'h0010, 1, 16'h0008);
    set_vec(28, 0, 0, 16'h0000, 0, 16'h0010, 1, 16'h0008);

    rstn     = 1'b0;
    dec_rdy  = 1'b1;
    redir_e  = 1'b0;
    redir_pc = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_reset_outputs("por");
    @(posedge clk);
    #2 rstn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Asynchronous reset while the FIFO is full.
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_rst");
    dec_rdy = 1'b1;
    @(negedge clk);
    #1 check("rst_hold ins_e", 32'(ins_e), 32'h0);
    check("rst_hold dec_vld", 32'(dec_vld), 32'h0);
    @(posedge clk);
    #2 rstn = 1'b1;

    for (int i = 0; i <= 4; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
